// File: rtl/hack_pkg.sv
// Shared types for the Hack bitwise datapath: op encoding, sequencer state
// and a counter-width helper.
package hack_pkg;

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NAND   = 3'd3,
    OP_NOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_NOT_A  = 3'd6,
    OP_PASS_A = 3'd7
  } bw_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } bw_state_t;

  // Slice counter needs at least one bit even when a single slice covers the word.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bitwise_slice.sv
// Combinational SLICE-bit evaluator for the eight bitwise operations.
module bitwise_slice
  import hack_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  bw_op_t           op,
  output logic [SLICE-1:0] y
);

  always_comb begin
    y = a;
    case (op)
      OP_AND:    y = a & b;
      OP_OR:     y = a | b;
      OP_XOR:    y = a ^ b;
      OP_NAND:   y = ~(a & b);
      OP_NOR:    y = ~(a | b);
      OP_XNOR:   y = ~(a ^ b);
      OP_NOT_A:  y = ~a;
      OP_PASS_A: y = a;
      default:   y = a;
    endcase
  end

endmodule

// File: rtl/bitwise_seq.sv
// Multi-cycle bitwise logic unit: WIDTH-bit op evaluated SLICE bits per clock,
// LSB slice first. Define BITWISE_SEQ_FLAGS_EN to add registered zr/ng flags.
//
// state | meaning
// IDLE  | in_ready=1, waiting for an operation
// BUSY  | one slice per cycle, operands shifted right by SLICE
// DONE  | out_valid=1, result held until out_ready
module bitwise_seq
  import hack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
`ifdef BITWISE_SEQ_FLAGS_EN
  ,
  output logic             zr,
  output logic             ng
`endif
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = clog2_min1(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_slice
      $error("bitwise_seq: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  bw_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sh_a, sh_b;
  bw_op_t           op_q;
  logic [WIDTH-1:0] out_q, out_nxt;
  logic [SLICE-1:0] y;
  logic             load, step;

  bitwise_slice #(.SLICE(SLICE)) u_slice (
    .a  (sh_a[SLICE-1:0]),
    .b  (sh_b[SLICE-1:0]),
    .op (op_q),
    .y  (y)
  );

  // Only the current slice changes; the rest of out keeps the previous result.
  always_comb begin
    out_nxt = out_q;
    out_nxt[int'(cnt_q)*SLICE +: SLICE] = y;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        step = 1'b1;
        if (cnt_q == LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_a    <= '0;
      sh_b    <= '0;
      op_q    <= OP_AND;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        sh_a  <= a;
        sh_b  <= b;
        op_q  <= bw_op_t'(op);
        cnt_q <= '0;
      end else if (step) begin
        sh_a  <= sh_a >> SLICE;
        sh_b  <= sh_b >> SLICE;
        out_q <= out_nxt;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign out = out_q;

`ifdef BITWISE_SEQ_FLAGS_EN
  // Flags are taken from the full word as it stands after the final slice write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zr <= 1'b0;
      ng <= 1'b0;
    end else if (step && cnt_q == LAST) begin
      zr <= (out_nxt == '0);
      ng <= out_nxt[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_bitwise_seq.sv
// Scoreboard bench for bitwise_seq (16/4 main instance, 32/32 single-slice instance).
module tb_bitwise_seq;
  import hack_pkg::*;

  localparam int WIDTH = 16;
  localparam int SLICE = 4;
  localparam int N     = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       op = 3'd0;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out;
`ifdef BITWISE_SEQ_FLAGS_EN
  logic             zr, ng, zr2, ng2;
`endif

  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic [2:0]  op2 = 3'd0;
  logic [31:0] a2 = '0, b2 = '0;
  logic        out_valid2;
  logic        out_ready2 = 1'b1;
  logic [31:0] out2;

  always #5 clk = ~clk;

  bitwise_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
`ifdef BITWISE_SEQ_FLAGS_EN
    ,
    .zr        (zr),
    .ng        (ng)
`endif
  );

  bitwise_seq #(.WIDTH(32), .SLICE(32)) dut_wide (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .op        (op2),
    .a         (a2),
    .b         (b2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .out       (out2)
`ifdef BITWISE_SEQ_FLAGS_EN
    ,
    .zr        (zr2),
    .ng        (ng2)
`endif
  );

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zr;
    logic             ng;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, acc_cyc = 0, prev_acc = 0;
  bit   have_prev = 0, b2b = 0;
  logic prev_ov = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model(input logic [2:0] o, input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] z);
    case (o)
      3'd0: return x & z;
      3'd1: return x | z;
      3'd2: return x ^ z;
      3'd3: return ~(x & z);
      3'd4: return ~(x | z);
      3'd5: return ~(x ^ z);
      3'd6: return ~x;
      default: return x;
    endcase
  endfunction

  function automatic exp_t mk_exp(input logic [2:0] o, input logic [WIDTH-1:0] x,
                                  input logic [WIDTH-1:0] z);
    exp_t e;
    e.res = model(o, x, z);
    e.zr  = (e.res == '0);
    e.ng  = e.res[WIDTH-1];
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Accept monitor: the handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      sb.push_back(mk_exp(op, a, b));
      acc_cyc = cyc + 1;
      if (b2b && have_prev) check("issue_gap", 64'(acc_cyc - prev_acc), 64'(N + 2));
      prev_acc  = acc_cyc;
      have_prev = 1;
    end
  end

  // Output monitor: latency on the rising edge of out_valid, result on transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) check("latency", 64'(cyc - acc_cyc), 64'(N));
      prev_ov = out_valid;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_out", 64'(1), 64'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out", out, e.res);
`ifdef BITWISE_SEQ_FLAGS_EN
          check("zr", zr, e.zr);
          check("ng", ng, e.ng);
`endif
        end
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] z);
    int k;
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; a = x; b = z;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!in_ready && k < 50);
    if (!in_ready) check("accept_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int k;
    k = 0;
    while (!(out_valid && out_ready) && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!(out_valid && out_ready)) check("out_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    #22 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out", out, '0);

    issue(3'd0, 16'hF0F0, 16'hFF00);
    wait_out();

    out_ready = 1'b0;
    issue(3'd2, 16'hA5A5, 16'hA5A5);
    k = 0;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1'b1);
      check("hold_out", out, 16'h0000);
      check("hold_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_out();

    for (int o = 0; o < 8; o++) begin
      issue(3'(o), 16'h1234, 16'h0FF0);
      wait_out();
    end

    b2b = 1; have_prev = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; op = 3'd1; a = 16'h00FF; b = 16'h0F0F;
    for (int i = 0; i < 5; i++) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!in_ready && k < 50);
      if (!in_ready) check("b2b_accept_timeout", 64'(0), 64'(1));
      @(posedge clk); #1;
      if (i == 4) in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom); op = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
      a = 16'($urandom); b = 16'($urandom); op = 3'($urandom_range(0, 7));
    end
    b2b = 0;
    wait_out();

    issue(3'd1, 16'h1234, 16'h0FF0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_out", out, '0);
    check("abort_in_ready", in_ready, 1'b1);
    issue(3'd5, 16'hC3C3, 16'h0F0F);
    wait_out();

    @(posedge clk); #1;
    check("wide_in_ready", in_ready2, 1'b1);
    in_valid2 = 1'b1; op2 = 3'd4; a2 = '0; b2 = '0;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    check("wide_busy", out_valid2, 1'b0);
    @(posedge clk); #1;
    check("wide_valid", out_valid2, 1'b1);
    check("wide_out", out2, 32'hFFFF_FFFF);

    repeat (3) @(posedge clk);
    check("sb_drain", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
